decrypt: RTL and testbench
==========================

# decrypt

LWE decryption stage, directly downstream of `encrypt`. It consumes one ciphertext, streamed as LITTLE_N mask elements a_i followed by the body element b. Secret-key elements s_i arrive in lockstep with the mask elements. The block computes d = b − Σ a_i·s_i mod q and rounds d to the nearest plaintext symbol, m = round(p·d/q) mod p.

## Interface
Parameters:
- PLAINTEXT_WIDTH, 8: log2(p); plaintext symbol width.
- CIPHERTEXT_WIDTH, 10: log2(q); width of ciphertext and key elements.
- CIPHERTEXT_MODULUS, 1024: q. Must equal 2^CIPHERTEXT_WIDTH.
- LITTLE_N, 2: n, the number of mask elements (and key elements) per ciphertext.
- Constraint: CIPHERTEXT_WIDTH ≥ PLAINTEXT_WIDTH+1. Violations abort elaboration.

Ports:
- clk, input, 1: the single clock.
- rst_n, input, 1: reset; asynchronous and active-low.
- go, input, 1: one-cycle start pulse; honoured only in IDLE.
- in_valid, input, 1: ciphertext_elem (and secretkey_elem, on mask beats) is valid.
- in_ready, output, 1: the block accepts a beat this cycle.
- ciphertext_elem, input, CIPHERTEXT_WIDTH: a_i on beats 0..n−1; b on beat n.
- secretkey_elem, input, CIPHERTEXT_WIDTH: s_i on beats 0..n−1; ignored on beat n.
- elem_idx, output, clog2(LITTLE_N+1): index of the beat expected next; upstream uses it as the key-memory address.
- plaintext, output, PLAINTEXT_WIDTH: recovered symbol.
- out_valid, input/output handshake: out_valid is an output, 1 bit; plaintext is valid.
- out_ready, input, 1: the consumer takes plaintext.
- busy, output, 1: high in every state except IDLE.

## Operation
- FSM states: IDLE, ACCUM, ROUND, DONE.
- IDLE:
  - in_ready=0 and out_valid=0.
  - On go: clear acc and elem_idx, then go to ACCUM.
- ACCUM:
  - in_ready=1.
  - Each accepted beat (in_valid && in_ready) with elem_idx<n: acc ← (acc + a·s) mod q, then elem_idx++.
  - Accepted beat with elem_idx==n: diff ← (b − acc) mod q, then go to ROUND.
  - Bubbles (in_valid=0) stall the FSM with no state change.
- ROUND:
  - plaintext ← ((diff + 2^(CW−PW−1)) >> (CW−PW)) mod 2^PW, where CW = CIPHERTEXT_WIDTH and PW = PLAINTEXT_WIDTH.
  - Go to DONE.
- DONE:
  - out_valid=1; plaintext held stable.
  - On out_ready: go to IDLE and drop out_valid.
- Arithmetic width rules:
  - The product a·s is formed at 2·CW bits and truncated to its low CW bits; mod q is truncation only.
  - The rounding adder is CW+1 bits wide. Any carry out of it is discarded by the final mod 2^PW, so values just below q round to 0.
- go is ignored while busy=1; it does not restart an operation in progress.
- Mid-operation reset: all state returns to IDLE, all registers clear, and the partial ciphertext is discarded.

## Timing
- Reset values: in_ready=0, out_valid=0, busy=0, plaintext=0, elem_idx=0; acc and diff are 0.
- Start: go sampled at edge t gives in_ready=1 and busy=1 from t+1.
- Throughput: one beat per cycle when in_valid is held high. n+1 beats occupy cycles t+1 .. t+n+1.
- Latency: the final beat accepted at edge k gives out_valid=1 from k+2, with plaintext valid in that same cycle.
- Output handshake: transfer occurs on the edge where out_valid && out_ready. The next go is accepted no earlier than the cycle after that transfer.
- Backpressure: out_valid and plaintext are held indefinitely while out_ready=0. in_ready stays 0 during ROUND and DONE.
- elem_idx is registered. It changes only on accepted beats or on go.

## Structure
- Shared package `lwe_pkg`:
  - The default widths, q, and n.
  - The FSM state enum.
  - The rounding-offset constant 2^(CW−PW−1).
  - Function `mod_q_mac(acc, a, s)`, shared with `encrypt`.
- One sub-module, `lwe_round`: combinational diff → plaintext rounding, registered in ROUND by the parent.

## Test plan
Setup for all scenarios: p=256, q=1024, n=2, so q/p=4.
- Nominal: s=(3,5), a=(10,20), b=151 (m=5, e=+1). plaintext=5, out_valid at final-beat edge +2.
- Modular wrap:
  - Inputs: s=(1000,7), a=(1000,3), b=596 (m=0, e=−1).
  - Expected internals: acc=597, diff=1023.
  - Expected output: plaintext=0.
- Top symbol: s=(3,5), a=(10,20), b=127 (m=255, e=+1). diff=1021 → plaintext=255.
- Bubbles and backpressure:
  - Stimulus: nominal vectors with in_valid low for 2 cycles between beats; out_ready low for 5 cycles.
  - Required: plaintext=5 held stable, in_ready=0 while held, and a go pulse during the hold is ignored.
- Reset mid-op:
  - Stimulus: rst_n low after one accepted beat.
  - Required: all outputs at reset values immediately; a fresh nominal run then yields plaintext=5.
- elem_idx sequence across a run is 0, 1, 2, then returns to 0 on the next go.

Source files
------------

// File: rtl/lwe_pkg.sv
// ==== lwe_pkg : shared LWE widths, FSM states and modular MAC helper (rev 1.0) ====
`default_nettype none

package lwe_pkg;

   localparam int LWE_PW           = 8;
   localparam int LWE_CW           = 10;
   localparam int LWE_Q            = 1024;
   localparam int LWE_N            = 2;
   localparam int LWE_ROUND_OFFSET = 2 ** (LWE_CW - LWE_PW - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_ROUND = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // q is a power of two, so every mod q below is plain truncation.
   function automatic logic [LWE_CW-1:0] mod_q_mac(input logic [LWE_CW-1:0] acc,
                                                   input logic [LWE_CW-1:0] a,
                                                   input logic [LWE_CW-1:0] s);
      return acc + LWE_CW'({{LWE_CW{1'b0}}, a} * {{LWE_CW{1'b0}}, s});
   endfunction

endpackage

`default_nettype wire

// File: rtl/lwe_round.sv
// ==== lwe_round : diff -> nearest plaintext symbol, round-half-up (rev 1.0) ====
`default_nettype none

module lwe_round
   import lwe_pkg::*;
#(
   parameter int PLAINTEXT_WIDTH  = LWE_PW,
   parameter int CIPHERTEXT_WIDTH = LWE_CW
) (
   input  logic [CIPHERTEXT_WIDTH-1:0] diff,
   output logic [PLAINTEXT_WIDTH-1:0]  plaintext
);

   localparam logic [CIPHERTEXT_WIDTH:0] OFFSET =
      (CIPHERTEXT_WIDTH+1)'(1) << (CIPHERTEXT_WIDTH - PLAINTEXT_WIDTH - 1);

   // The carry out of the CW+1-bit sum falls off in the final truncation, so diff near q wraps to 0.
   always_comb begin
      plaintext = PLAINTEXT_WIDTH'(({1'b0, diff} + OFFSET) >> (CIPHERTEXT_WIDTH - PLAINTEXT_WIDTH));
   end

endmodule

`default_nettype wire

// File: rtl/decrypt.sv
// ==== decrypt : LWE decryption, d = b - sum(a_i*s_i) mod q, m = round(p*d/q) (rev 1.0) ====
`default_nettype none

module decrypt
   import lwe_pkg::*;
#(
   parameter int PLAINTEXT_WIDTH    = LWE_PW,
   parameter int CIPHERTEXT_WIDTH   = LWE_CW,
   parameter int CIPHERTEXT_MODULUS = LWE_Q,
   parameter int LITTLE_N           = LWE_N,
   localparam int IDX_W             = $clog2(LITTLE_N + 1)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        go,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [CIPHERTEXT_WIDTH-1:0] ciphertext_elem,
   input  logic [CIPHERTEXT_WIDTH-1:0] secretkey_elem,
   output logic [IDX_W-1:0]            elem_idx,
   output logic [PLAINTEXT_WIDTH-1:0]  plaintext,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic                        busy
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LITTLE_N);

   generate
      if (CIPHERTEXT_WIDTH < PLAINTEXT_WIDTH + 1) begin : g_bad_width
         $fatal(1, "decrypt: CIPHERTEXT_WIDTH must be at least PLAINTEXT_WIDTH+1");
      end
      if (CIPHERTEXT_MODULUS != 2 ** CIPHERTEXT_WIDTH) begin : g_bad_modulus
         $fatal(1, "decrypt: CIPHERTEXT_MODULUS must equal 2**CIPHERTEXT_WIDTH");
      end
   endgenerate

   state_t                      state;
   state_t                      state_nxt;
   logic [CIPHERTEXT_WIDTH-1:0] acc;
   logic [CIPHERTEXT_WIDTH-1:0] diff;
   logic [CIPHERTEXT_WIDTH-1:0] mac;
   logic [PLAINTEXT_WIDTH-1:0]  rounded;
   logic                        beat;

   generate
      if (CIPHERTEXT_WIDTH == LWE_CW) begin : g_pkg_mac
         always_comb mac = mod_q_mac(acc, ciphertext_elem, secretkey_elem);
      end else begin : g_local_mac
         always_comb mac = acc + CIPHERTEXT_WIDTH'({{CIPHERTEXT_WIDTH{1'b0}}, ciphertext_elem} *
                                                   {{CIPHERTEXT_WIDTH{1'b0}}, secretkey_elem});
      end
   endgenerate

   lwe_round #(
      .PLAINTEXT_WIDTH  (PLAINTEXT_WIDTH),
      .CIPHERTEXT_WIDTH (CIPHERTEXT_WIDTH)
   ) u_round (
      .diff      (diff),
      .plaintext (rounded)
   );

   always_comb beat = in_valid && in_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (go) state_nxt = ST_ACCUM;
         ST_ACCUM: if (beat && elem_idx == LAST_IDX) state_nxt = ST_ROUND;
         ST_ROUND: state_nxt = ST_DONE;
         ST_DONE:  if (out_ready) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == ST_ACCUM);
      out_valid = (state == ST_DONE);
      busy      = (state != ST_IDLE);
   end

   // elem_idx parks at n after the body beat and only clears on the next go.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc       <= '0;
         diff      <= '0;
         elem_idx  <= '0;
         plaintext <= '0;
      end else begin
         if (state == ST_IDLE && go) begin
            acc      <= '0;
            elem_idx <= '0;
         end
         if (beat) begin
            if (elem_idx < LAST_IDX) begin
               acc      <= mac;
               elem_idx <= elem_idx + IDX_W'(1);
            end else begin
               diff <= ciphertext_elem - acc;
            end
         end
         if (state == ST_ROUND) begin
            plaintext <= rounded;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_decrypt.sv
// ==== tb_decrypt : randomized and directed checks of decrypt against a behavioural model (rev 1.0) ====
`default_nettype none

module tb_decrypt;

   localparam int PW = 8;
   localparam int CW = 10;
   localparam int Q  = 1024;
   localparam int P  = 256;
   localparam int N  = 2;
   localparam int IW = 2;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          go = 1'b0;
   logic          in_valid = 1'b0;
   logic          out_ready = 1'b0;
   logic [CW-1:0] ciphertext_elem = '0;
   logic [CW-1:0] secretkey_elem = '0;
   logic          in_ready;
   logic          out_valid;
   logic          busy;
   logic [IW-1:0] elem_idx;
   logic [PW-1:0] plaintext;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   decrypt #(
      .PLAINTEXT_WIDTH    (PW),
      .CIPHERTEXT_WIDTH   (CW),
      .CIPHERTEXT_MODULUS (Q),
      .LITTLE_N           (N)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .go              (go),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .ciphertext_elem (ciphertext_elem),
      .secretkey_elem  (secretkey_elem),
      .elem_idx        (elem_idx),
      .plaintext       (plaintext),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .busy            (busy)
   );

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Nearest symbol to p*d/q, halves rounding up, taken mod p.
   function automatic int ref_symbol(input longint b, input longint sum);
      longint d;
      d = ((b - sum) % Q + Q) % Q;
      return int'(((d * P + Q / 2) / Q) % P);
   endfunction

   // Transaction-level model: phase 0 idle, 1 taking beats, 2 rounding, 3 presenting.
   int     m_phase = 0;
   int     m_cnt   = 0;
   int     m_pt    = 0;
   int     m_pend  = 0;
   longint m_sum   = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_phase = 0; m_cnt = 0; m_pt = 0; m_pend = 0; m_sum = 0;
      end else begin
         case (m_phase)
            0: if (go) begin m_phase = 1; m_cnt = 0; m_sum = 0; end
            1: if (in_valid) begin
                  if (m_cnt < N) begin
                     m_sum += longint'(ciphertext_elem) * longint'(secretkey_elem);
                     m_cnt++;
                  end else begin
                     m_pend  = ref_symbol(longint'(ciphertext_elem), m_sum);
                     m_phase = 2;
                  end
               end
            2: begin m_pt = m_pend; m_phase = 3; end
            default: if (out_ready) m_phase = 0;
         endcase
      end
   end

   always @(negedge clk) begin
      check("in_ready", longint'(in_ready), longint'(m_phase == 1));
      check("busy", longint'(busy), longint'(m_phase != 0));
      check("out_valid", longint'(out_valid), longint'(m_phase == 3));
      check("elem_idx", longint'(elem_idx), longint'(m_cnt));
      check("plaintext", longint'(plaintext), longint'(m_pt));
   end

   task automatic run_txn(input logic [CW-1:0] a0, input logic [CW-1:0] a1,
                          input logic [CW-1:0] s0, input logic [CW-1:0] s1,
                          input logic [CW-1:0] b, input int gap, input int hold,
                          input int exp_pt, input int exp_acc, input int exp_diff);
      logic [CW-1:0] av [3];
      logic [CW-1:0] sv [3];
      int lat;
      av[0] = a0; av[1] = a1; av[2] = b;
      sv[0] = s0; sv[1] = s1; sv[2] = CW'($urandom);
      @(posedge clk); #1 go = 1'b1;
      @(posedge clk); #1 go = 1'b0;
      check("idx_after_go", longint'(elem_idx), 0);
      for (int i = 0; i <= N; i++) begin
         for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            ciphertext_elem = CW'($urandom);
            secretkey_elem  = CW'($urandom);
            @(posedge clk); #1;
         end
         in_valid = 1'b1;
         ciphertext_elem = av[i];
         secretkey_elem  = sv[i];
         @(posedge clk); #1 in_valid = 1'b0;
         if (i < N) check("idx_step", longint'(elem_idx), longint'(i + 1));
         if (i == N - 1 && exp_acc >= 0) check("acc_lit", longint'(dut.acc), longint'(exp_acc));
      end
      check("out_valid_k1", longint'(out_valid), 0);
      lat = 0;
      while (!out_valid && lat < 20) begin
         @(posedge clk); #1 lat++;
      end
      check("latency", longint'(lat), 1);
      if (exp_pt >= 0) check("plaintext_lit", longint'(plaintext), longint'(exp_pt));
      if (exp_diff >= 0) check("diff_lit", longint'(dut.diff), longint'(exp_diff));
      for (int h = 0; h < hold; h++) begin
         go = (h == 1);
         @(posedge clk); #1;
         check("hold_in_ready", longint'(in_ready), 0);
         check("hold_out_valid", longint'(out_valid), 1);
         if (exp_pt >= 0) check("hold_plaintext", longint'(plaintext), longint'(exp_pt));
      end
      go = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1 out_ready = 1'b0;
      check("idle_after", longint'(busy), 0);
      check("idx_parked", longint'(elem_idx), longint'(N));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, n_checks %0d", n_checks);
      $fatal(1, "watchdog expired");
   end

   initial begin
      #1;
      check("rst_in_ready", longint'(in_ready), 0);
      check("rst_out_valid", longint'(out_valid), 0);
      check("rst_busy", longint'(busy), 0);
      check("rst_plaintext", longint'(plaintext), 0);
      check("rst_elem_idx", longint'(elem_idx), 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      run_txn(10, 20, 3, 5, 151, 0, 0, 5, -1, 21);
      run_txn(1000, 3, 1000, 7, 596, 0, 0, 0, 597, 1023);
      run_txn(10, 20, 3, 5, 127, 0, 0, 255, -1, 1021);
      run_txn(10, 20, 3, 5, 151, 2, 5, 5, 130, -1);

      @(posedge clk); #1 go = 1'b1;
      @(posedge clk); #1 go = 1'b0;
      in_valid = 1'b1; ciphertext_elem = 10; secretkey_elem = 3;
      @(posedge clk); #1 in_valid = 1'b0;
      check("mid_idx", longint'(elem_idx), 1);
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_in_ready", longint'(in_ready), 0);
      check("mid_rst_out_valid", longint'(out_valid), 0);
      check("mid_rst_busy", longint'(busy), 0);
      check("mid_rst_plaintext", longint'(plaintext), 0);
      check("mid_rst_elem_idx", longint'(elem_idx), 0);
      check("mid_rst_acc", longint'(dut.acc), 0);
      @(posedge clk); #1 rst_n = 1'b1;
      run_txn(10, 20, 3, 5, 151, 0, 0, 5, 130, 21);

      for (int t = 0; t < 40; t++) begin
         run_txn(CW'($urandom), CW'($urandom), CW'($urandom), CW'($urandom), CW'($urandom),
                 int'($urandom_range(0, 2)), int'($urandom_range(0, 4)), -1, -1, -1);
      end

      repeat (3) @(posedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
